// File: rtl/br_resolve.sv
// Branch-resolution stage: registers the branch FU result, checks the fetch prediction,
// reports completion/mispredict to the ROB, trains the predictor and sequences redirect + flush.
// Optional feature macro: BR_MISALIGN_EXC_EN (taken targets with bit 1 set raise cmpl_exception).
module br_resolve #(
    parameter int XLEN         = 32,
    parameter int ROB_IDX_W    = 6,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic                 ex_cond,
    input  logic [XLEN-1:0]      ex_target,
    input  logic [6:0]           ex_opcode,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic                 ex_pred_taken,
    input  logic [XLEN-1:0]      ex_pred_target,
    input  logic [ROB_IDX_W-1:0] ex_rob_idx,
    input  logic                 rob_flush,
    output logic                 cmpl_valid,
    output logic [ROB_IDX_W-1:0] cmpl_rob_idx,
    output logic                 cmpl_mispredict,
`ifdef BR_MISALIGN_EXC_EN
    output logic                 cmpl_exception,
`endif
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush_frontend,
    output logic                 bp_upd_valid,
    output logic [XLEN-1:0]      bp_upd_pc,
    output logic                 bp_upd_taken,
    output logic [XLEN-1:0]      bp_upd_target
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
    logic                 ex_ready_r;
    logic                 redirect_valid_r, redirect_valid_nxt_s;
    logic                 flush_frontend_r, flush_frontend_nxt_s;
    logic [XLEN-1:0]      redirect_pc_r;
    logic                 cmpl_valid_r;
    logic [ROB_IDX_W-1:0] cmpl_rob_idx_r;
    logic                 cmpl_mispredict_r;
    logic                 cmpl_exception_r;
    logic                 bp_upd_valid_r;
    logic [XLEN-1:0]      bp_upd_pc_r;
    logic                 bp_upd_taken_r;
    logic [XLEN-1:0]      bp_upd_target_r;

    logic                 is_jal_s, is_jalr_s;
    logic                 actual_taken_s;
    logic [XLEN-1:0]      actual_target_s;
    logic [XLEN-1:0]      next_pc_s;
    logic                 mispredict_raw_s;
    logic                 mispredict_s;
    logic                 exc_s;
    logic                 accept_s;

    // Resolve the actual outcome of the offered result and compare with the prediction.
    always_comb begin
        is_jal_s  = (ex_opcode == OPC_JAL);
        is_jalr_s = (ex_opcode == OPC_JALR);
        if (is_jal_s || is_jalr_s) begin
            actual_taken_s = 1'b1;
        end else begin
            actual_taken_s = ex_cond;
        end
        if (is_jalr_s) begin
            actual_target_s = {ex_target[XLEN-1:1], 1'b0};
        end else begin
            actual_target_s = ex_target;
        end
        if (actual_taken_s) begin
            next_pc_s = actual_target_s;
        end else begin
            next_pc_s = ex_pc + XLEN'(4);
        end
        mispredict_raw_s = (actual_taken_s != ex_pred_taken) ||
                           (actual_taken_s && (actual_target_s != ex_pred_target));
    end

`ifdef BR_MISALIGN_EXC_EN
    assign exc_s = actual_taken_s & actual_target_s[1];
`else
    assign exc_s = 1'b0;
`endif

    // A misaligned-target exception never counts as a mispredict; rob_flush discards the offer.
    assign mispredict_s = mispredict_raw_s & ~exc_s;
    assign accept_s     = ex_valid & ex_ready_r & ~rob_flush;

    // Next-state and next-control-output logic for the redirect/flush sequencer.
    always_comb begin
        state_nxt_s          = state_r;
        cnt_nxt_s            = cnt_r;
        redirect_valid_nxt_s = redirect_valid_r;
        flush_frontend_nxt_s = flush_frontend_r;
        case (state_r)
            ST_IDLE: begin
                redirect_valid_nxt_s = 1'b0;
                flush_frontend_nxt_s = 1'b0;
                if (accept_s && mispredict_s) begin
                    state_nxt_s          = ST_REDIRECT;
                    redirect_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (rob_flush) begin
                    state_nxt_s          = ST_IDLE;
                    redirect_valid_nxt_s = 1'b0;
                    flush_frontend_nxt_s = 1'b0;
                end else if (redirect_ready) begin
                    state_nxt_s          = ST_FLUSH;
                    redirect_valid_nxt_s = 1'b0;
                    flush_frontend_nxt_s = 1'b1;
                    cnt_nxt_s            = CNT_W'(FLUSH_CYCLES);
                end else begin
                    state_nxt_s          = ST_REDIRECT;
                    redirect_valid_nxt_s = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The counter value seen here is the number of flush cycles still owed,
                // including the current one.
                if (rob_flush || (cnt_r <= CNT_W'(1))) begin
                    state_nxt_s          = ST_IDLE;
                    flush_frontend_nxt_s = 1'b0;
                    cnt_nxt_s            = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s          = ST_FLUSH;
                    flush_frontend_nxt_s = 1'b1;
                    cnt_nxt_s            = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s          = ST_IDLE;
                redirect_valid_nxt_s = 1'b0;
                flush_frontend_nxt_s = 1'b0;
                cnt_nxt_s            = {CNT_W{1'b0}};
            end
        endcase
    end

    // Sequencer state and registered control outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            ex_ready_r       <= 1'b1;
            redirect_valid_r <= 1'b0;
            flush_frontend_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
        end else begin
            state_r          <= state_nxt_s;
            cnt_r            <= cnt_nxt_s;
            ex_ready_r       <= (state_nxt_s == ST_IDLE);
            redirect_valid_r <= redirect_valid_nxt_s;
            flush_frontend_r <= flush_frontend_nxt_s;
            if (accept_s && mispredict_s) begin
                redirect_pc_r <= next_pc_s;
            end
        end
    end

    // Completion and predictor-update pulses, one cycle after acceptance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cmpl_valid_r      <= 1'b0;
            cmpl_rob_idx_r    <= {ROB_IDX_W{1'b0}};
            cmpl_mispredict_r <= 1'b0;
            cmpl_exception_r  <= 1'b0;
            bp_upd_valid_r    <= 1'b0;
            bp_upd_pc_r       <= {XLEN{1'b0}};
            bp_upd_taken_r    <= 1'b0;
            bp_upd_target_r   <= {XLEN{1'b0}};
        end else begin
            cmpl_valid_r      <= accept_s;
            cmpl_mispredict_r <= accept_s & mispredict_s;
            cmpl_exception_r  <= accept_s & exc_s;
            bp_upd_valid_r    <= accept_s & ~exc_s;
            bp_upd_taken_r    <= accept_s & ~exc_s & actual_taken_s;
            if (accept_s) begin
                cmpl_rob_idx_r <= ex_rob_idx;
            end
            if (accept_s && !exc_s) begin
                bp_upd_pc_r     <= ex_pc;
                bp_upd_target_r <= actual_target_s;
            end
        end
    end

    assign ex_ready        = ex_ready_r;
    assign cmpl_valid      = cmpl_valid_r;
    assign cmpl_rob_idx    = cmpl_rob_idx_r;
    assign cmpl_mispredict = cmpl_mispredict_r;
`ifdef BR_MISALIGN_EXC_EN
    assign cmpl_exception  = cmpl_exception_r;
`else
    logic unused_exc_s;
    assign unused_exc_s    = cmpl_exception_r;
`endif
    assign redirect_valid  = redirect_valid_r;
    assign redirect_pc     = redirect_pc_r;
    assign flush_frontend  = flush_frontend_r;
    assign bp_upd_valid    = bp_upd_valid_r;
    assign bp_upd_pc       = bp_upd_pc_r;
    assign bp_upd_taken    = bp_upd_taken_r;
    assign bp_upd_target   = bp_upd_target_r;

endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve: hand-computed expectations checked with immediate assertions.
module tb_br_resolve;

    localparam int XLEN = 32;
    localparam int RW   = 6;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_cond;
    logic [XLEN-1:0] ex_target;
    logic [6:0]      ex_opcode;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic [RW-1:0]   ex_rob_idx;
    logic            rob_flush;
    logic            cmpl_valid;
    logic [RW-1:0]   cmpl_rob_idx;
    logic            cmpl_mispredict;
`ifdef BR_MISALIGN_EXC_EN
    logic            cmpl_exception;
`endif
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            flush_frontend;
    logic            bp_upd_valid;
    logic [XLEN-1:0] bp_upd_pc;
    logic            bp_upd_taken;
    logic [XLEN-1:0] bp_upd_target;

    int passed = 0;
    int total  = 0;

    br_resolve #(.XLEN(XLEN), .ROB_IDX_W(RW), .FLUSH_CYCLES(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_cond(ex_cond),
        .ex_target(ex_target), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_rob_idx(ex_rob_idx), .rob_flush(rob_flush),
        .cmpl_valid(cmpl_valid), .cmpl_rob_idx(cmpl_rob_idx),
        .cmpl_mispredict(cmpl_mispredict),
`ifdef BR_MISALIGN_EXC_EN
        .cmpl_exception(cmpl_exception),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush_frontend(flush_frontend),
        .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
        .bp_upd_taken(bp_upd_taken), .bp_upd_target(bp_upd_target)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [6:0] opc, input logic [31:0] pc, input logic cond,
                         input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                         input logic [5:0] idx);
        ex_valid = 1'b1; ex_opcode = opc; ex_pc = pc; ex_cond = cond;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt; ex_rob_idx = idx;
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_cond = 1'b0; ex_target = 32'h0;
        ex_opcode = 7'b0; ex_pc = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        ex_rob_idx = 6'd0; rob_flush = 1'b0; redirect_ready = 1'b0;
        tick(); tick();
        chk("rst_cmpl_valid", {63'd0, cmpl_valid}, 64'd0);
        chk("rst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("rst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
        chk("rst_flush", {63'd0, flush_frontend}, 64'd0);
        chk("rst_bp_upd_valid", {63'd0, bp_upd_valid}, 64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);

        // BEQ correctly predicted taken, followed back-to-back by JALR with bit 0 set.
        offer(7'b1100011, 32'h100, 1'b1, 32'h140, 1'b1, 32'h140, 6'd5);
        tick();
        chk("beq_cmpl_valid", {63'd0, cmpl_valid}, 64'd1);
        chk("beq_rob_idx", {58'd0, cmpl_rob_idx}, 64'd5);
        chk("beq_mispredict", {63'd0, cmpl_mispredict}, 64'd0);
        chk("beq_bp_valid", {63'd0, bp_upd_valid}, 64'd1);
        chk("beq_bp_taken", {63'd0, bp_upd_taken}, 64'd1);
        chk("beq_bp_pc", {32'd0, bp_upd_pc}, 64'h100);
        chk("beq_redirect", {63'd0, redirect_valid}, 64'd0);
        chk("beq_ex_ready", {63'd0, ex_ready}, 64'd1);
        offer(7'b1100111, 32'h300, 1'b0, 32'h1235, 1'b1, 32'h1234, 6'd6);
        tick();
        chk("jalr_cmpl_valid", {63'd0, cmpl_valid}, 64'd1);
        chk("jalr_rob_idx", {58'd0, cmpl_rob_idx}, 64'd6);
        chk("jalr_mispredict", {63'd0, cmpl_mispredict}, 64'd0);
        chk("jalr_bp_target", {32'd0, bp_upd_target}, 64'h1234);
        chk("jalr_bp_taken", {63'd0, bp_upd_taken}, 64'd1);
        chk("jalr_redirect", {63'd0, redirect_valid}, 64'd0);
        ex_valid = 1'b0;
        tick();
        chk("idle_cmpl_valid", {63'd0, cmpl_valid}, 64'd0);
        chk("idle_bp_valid", {63'd0, bp_upd_valid}, 64'd0);

        // BNE mispredicted taken; fetch stalls the redirect for three cycles.
        offer(7'b1100011, 32'h200, 1'b0, 32'h180, 1'b1, 32'h180, 6'd7);
        tick();
        ex_valid = 1'b0;
        chk("bne_cmpl_valid", {63'd0, cmpl_valid}, 64'd1);
        chk("bne_mispredict", {63'd0, cmpl_mispredict}, 64'd1);
        chk("bne_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("bne_redirect_pc", {32'd0, redirect_pc}, 64'h204);
        chk("bne_bp_taken", {63'd0, bp_upd_taken}, 64'd0);
        chk("bne_ex_ready", {63'd0, ex_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_redirect_valid", {63'd0, redirect_valid}, 64'd1);
            chk("hold_redirect_pc", {32'd0, redirect_pc}, 64'h204);
            chk("hold_ex_ready", {63'd0, ex_ready}, 64'd0);
            chk("hold_cmpl_valid", {63'd0, cmpl_valid}, 64'd0);
            chk("hold_flush", {63'd0, flush_frontend}, 64'd0);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        chk("acc_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("flush_c1", {63'd0, flush_frontend}, 64'd1);
        chk("flush_c1_ready", {63'd0, ex_ready}, 64'd0);
        tick();
        chk("flush_c2", {63'd0, flush_frontend}, 64'd1);
        tick();
        chk("flush_end", {63'd0, flush_frontend}, 64'd0);
        chk("flush_end_ready", {63'd0, ex_ready}, 64'd1);

        // Not-taken mispredict at the top of the address space; redirect accepted at once.
        offer(7'b1100011, 32'hFFFFFFFC, 1'b0, 32'h40, 1'b1, 32'h40, 6'd10);
        tick();
        ex_valid = 1'b0;
        redirect_ready = 1'b1;
        chk("wrap_mispredict", {63'd0, cmpl_mispredict}, 64'd1);
        chk("wrap_redirect_valid", {63'd0, redirect_valid}, 64'd1);
        chk("wrap_redirect_pc", {32'd0, redirect_pc}, 64'h0);
        tick();
        redirect_ready = 1'b0;
        chk("wrap_acc_valid", {63'd0, redirect_valid}, 64'd0);
        chk("wrap_flush_c1", {63'd0, flush_frontend}, 64'd1);
        tick();
        chk("wrap_flush_c2", {63'd0, flush_frontend}, 64'd1);
        tick();
        chk("wrap_flush_end", {63'd0, flush_frontend}, 64'd0);

        // JAL mispredicted not-taken, squashed by rob_flush together with redirect_ready.
        offer(7'b1101111, 32'h400, 1'b0, 32'h800, 1'b0, 32'h0, 6'd11);
        tick();
        ex_valid = 1'b0;
        chk("jal_mispredict", {63'd0, cmpl_mispredict}, 64'd1);
        chk("jal_redirect_pc", {32'd0, redirect_pc}, 64'h800);
        chk("jal_bp_taken", {63'd0, bp_upd_taken}, 64'd1);
        rob_flush = 1'b1; redirect_ready = 1'b1;
        tick();
        rob_flush = 1'b0; redirect_ready = 1'b0;
        chk("sq_redirect_valid", {63'd0, redirect_valid}, 64'd0);
        chk("sq_flush", {63'd0, flush_frontend}, 64'd0);
        chk("sq_ex_ready", {63'd0, ex_ready}, 64'd1);
        offer(7'b1100011, 32'h500, 1'b0, 32'h520, 1'b0, 32'h0, 6'd12);
        tick();
        chk("post_sq_cmpl_valid", {63'd0, cmpl_valid}, 64'd1);
        chk("post_sq_rob_idx", {58'd0, cmpl_rob_idx}, 64'd12);
        chk("post_sq_mispredict", {63'd0, cmpl_mispredict}, 64'd0);
        chk("post_sq_bp_target", {32'd0, bp_upd_target}, 64'h520);

        // A result offered together with rob_flush is discarded.
        offer(7'b1100011, 32'h600, 1'b1, 32'h700, 1'b0, 32'h0, 6'd13);
        rob_flush = 1'b1;
        tick();
        rob_flush = 1'b0; ex_valid = 1'b0;
        chk("drop_cmpl_valid", {63'd0, cmpl_valid}, 64'd0);
        chk("drop_bp_valid", {63'd0, bp_upd_valid}, 64'd0);
        chk("drop_redirect", {63'd0, redirect_valid}, 64'd0);
        chk("drop_ex_ready", {63'd0, ex_ready}, 64'd1);

        // Taken branch to a halfword-aligned target.
        offer(7'b1100011, 32'h100, 1'b1, 32'h102, 1'b0, 32'h0, 6'd14);
        tick();
        ex_valid = 1'b0;
        chk("mis_cmpl_valid", {63'd0, cmpl_valid}, 64'd1);
`ifdef BR_MISALIGN_EXC_EN
        chk("mis_exception", {63'd0, cmpl_exception}, 64'd1);
        chk("mis_mispredict", {63'd0, cmpl_mispredict}, 64'd0);
        chk("mis_redirect", {63'd0, redirect_valid}, 64'd0);
        chk("mis_bp_valid", {63'd0, bp_upd_valid}, 64'd0);
        chk("mis_ex_ready", {63'd0, ex_ready}, 64'd1);
`else
        chk("mis_mispredict", {63'd0, cmpl_mispredict}, 64'd1);
        chk("mis_redirect", {63'd0, redirect_valid}, 64'd1);
        chk("mis_redirect_pc", {32'd0, redirect_pc}, 64'h102);
        chk("mis_bp_valid", {63'd0, bp_upd_valid}, 64'd1);
`endif

        // Reset while a redirect may be pending clears everything.
        offer(7'b1100011, 32'h900, 1'b0, 32'h0, 1'b1, 32'h980, 6'd15);
        tick();
        ex_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("mid_rst_redirect", {63'd0, redirect_valid}, 64'd0);
        chk("mid_rst_redirect_pc", {32'd0, redirect_pc}, 64'h0);
        chk("mid_rst_cmpl_valid", {63'd0, cmpl_valid}, 64'd0);
        chk("mid_rst_ex_ready", {63'd0, ex_ready}, 64'd1);
        tick();
        chk("mid_rst_flush", {63'd0, flush_frontend}, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
